// File: rtl/wb_arbiter.sv
// Integer register-file writeback arbiter: main pipeline has priority, mul/div
// results are queued in a circular FIFO and drain into idle writeback slots.
module wb_arbiter #(
  parameter int XLEN       = 64,
  parameter int ADDR_SIZE  = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pipe_valid,
  input  logic [ADDR_SIZE-1:0]          pipe_rd,
  input  logic [XLEN-1:0]               pipe_data,
  input  logic                          pipe_load,
  input  logic [2:0]                    pipe_funct3,
  input  logic [2:0]                    pipe_addr_low,
  input  logic                          muldiv_valid,
  output logic                          muldiv_ready,
  input  logic [ADDR_SIZE-1:0]          muldiv_rd,
  input  logic [XLEN-1:0]               muldiv_data,
  input  logic [ADDR_SIZE-1:0]          query_rs1,
  input  logic [ADDR_SIZE-1:0]          query_rs2,
  output logic                          query_hit,
  output logic                          rf_write_enable,
  output logic [ADDR_SIZE-1:0]          rf_write_addr,
  output logic [XLEN-1:0]               rf_write_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_SIZE-1:0] r_rd   [FIFO_DEPTH];
  logic [XLEN-1:0]      r_data [FIFO_DEPTH];
  logic [PW-1:0]        r_wptr, r_rptr;
  logic [CW-1:0]        r_count;

  logic                 r_we_p1;
  logic [ADDR_SIZE-1:0] r_addr_p1;
  logic [XLEN-1:0]      r_data_p1;

  logic                 w_ready, w_push, w_pipe_wr, w_pop, w_hit;
  logic [PW-1:0]        w_idx;
  logic [XLEN-1:0]      w_pipe_result;

  function automatic logic [XLEN-1:0] load_extract(
    input logic [XLEN-1:0] data,
    input logic [2:0]      f3,
    input logic [2:0]      off
  );
    logic [XLEN-1:0]    b_sh, h_sh, w_sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    b_sh = data >> {off, 3'b000};
    h_sh = data >> {off[2:1], 4'b0000};
    w_sh = data >> {off[2], 5'b00000};
    b    = b_sh[7:0];
    h    = h_sh[15:0];
    w    = w_sh[31:0];
    case (f3)
      3'b000:  load_extract = {{(XLEN-8){b[7]}}, b};
      3'b100:  load_extract = {{(XLEN-8){1'b0}}, b};
      3'b001:  load_extract = {{(XLEN-16){h[15]}}, h};
      3'b101:  load_extract = {{(XLEN-16){1'b0}}, h};
      3'b010:  load_extract = {{(XLEN-32){w[31]}}, w};
      3'b110:  load_extract = {{(XLEN-32){1'b0}}, w};
      default: load_extract = data;
    endcase
  endfunction

  // Ready depends on the current count only, so a full queue stays closed
  // even when a pop happens in the same cycle.
  assign w_ready       = (r_count < CW'(FIFO_DEPTH));
  assign w_push        = muldiv_valid && w_ready && (muldiv_rd != '0);
  assign w_pipe_wr     = pipe_valid && (pipe_rd != '0);
  assign w_pop         = !w_pipe_wr && (r_count != '0);
  assign w_pipe_result = pipe_load ? load_extract(pipe_data, pipe_funct3, pipe_addr_low)
                                   : pipe_data;

  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      w_idx = r_rptr + PW'(i);
      if ((CW'(i) < r_count) &&
          (((query_rs1 != '0) && (r_rd[w_idx] == query_rs1)) ||
           ((query_rs2 != '0) && (r_rd[w_idx] == query_rs2))))
        w_hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd[r_wptr]   <= muldiv_rd;
      r_data[r_wptr] <= muldiv_data;
    end
  end

  // Stage p0 -> p1: queue bookkeeping and registered writeback slot
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_we_p1   <= 1'b0;
      r_addr_p1 <= '0;
      r_data_p1 <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_pipe_wr) begin
        r_we_p1   <= 1'b1;
        r_addr_p1 <= pipe_rd;
        r_data_p1 <= w_pipe_result;
      end else if (w_pop) begin
        r_we_p1   <= 1'b1;
        r_addr_p1 <= r_rd[r_rptr];
        r_data_p1 <= r_data[r_rptr];
      end else begin
        r_we_p1   <= 1'b0;
        r_addr_p1 <= '0;
        r_data_p1 <= '0;
      end
    end
  end

  assign muldiv_ready    = w_ready;
  assign query_hit       = w_hit;
  assign fifo_count      = r_count;
  assign rf_write_enable = r_we_p1;
  assign rf_write_addr   = r_addr_p1;
  assign rf_write_data   = r_data_p1;

endmodule
